test_slave: RTL and testbench
=============================

# test_slave

Cycle-level behavioural model of an RS-232 UART register slave on an Avalon-MM bus, used to exercise a master (e.g. the VD wrapper) without a real UART. It exposes the UART's RX-data, TX-data and status registers to the bus master. It bridges them to two byte-wide rdy/ack streams: an incoming byte stream (`from232_*`) and an outgoing byte stream (`to232_*`). Each direction has a one-entry buffer.

## Interface
- No parameters.
- `avm_clk` in 1: single clock; all state updates on its rising edge.
- `avm_rst_n` in 1: asynchronous, active-low reset.
- `avm_address` in 5: byte address; 0 = RX data, 4 = TX data, 8 = status.
- `avm_actually_read` in 1: read accepted this cycle (read && ack, resolved by the bus).
- `avm_readdata` out 32: read data, valid in every cycle (combinational from `avm_address` and state).
- `avm_actually_write` in 1: write accepted this cycle.
- `avm_writedata` in 32: write data; bits [7:0] used.
- `to232_rdy` out 1: outgoing byte valid.
- `to232_ack` in 1: outgoing byte consumed.
- `to232_dat` out 8: outgoing byte.
- `from232_rdy` in 1: incoming byte valid.
- `from232_ack` out 1: incoming byte accepted.
- `from232_dat` in 8: incoming byte.
- Internal nets with fixed names for hierarchical protocol checkers: `tx_src_rdy`, `tx_src_ack`, `rx_dst_rdy`, `rx_dst_ack`.

## Operation
- Handshake convention on both streams: a transfer occurs in a cycle where rdy && ack at the rising edge.
- State:
  - `rx_valid`, `rx_dat[7:0]`
  - `tx_valid`, `tx_dat[7:0]`
- RX path:
  - `from232_ack = !rx_valid`.
  - On an incoming transfer, `rx_dat <= from232_dat` and `rx_valid <= 1`.
  - Bus read at address 0 with `avm_actually_read` while `rx_valid`: clears `rx_valid`.
- TX path:
  - `to232_rdy = tx_valid`, `to232_dat = tx_dat`.
  - Bus write at address 4 with `avm_actually_write` while `!tx_valid`: `tx_dat <= avm_writedata[7:0]`, `tx_valid <= 1`.
  - An outgoing transfer clears `tx_valid`.
- Read data:
  - Address 0: {24'b0, rx_dat}.
  - Address 8: bit 7 = `rx_valid` (RRDY), bit 6 = `!tx_valid` (TRDY), all other bits 0.
  - Any other address: 0.
- Writes to addresses other than 4 are ignored; reads of addresses other than 0 have no side effect.
- Checker nets:
  - `rx_dst_rdy = avm_actually_read && avm_address==0`, `rx_dst_ack = rx_valid`.
  - `tx_src_rdy = avm_actually_write && avm_address==4`, `tx_src_ack = !tx_valid`.
  - A strobe without the matching ack is a protocol violation by the master; external checkers flag it.
- Violation behaviour:
  - Read of RX while empty: returns stale `rx_dat`, no state change.
  - Write of TX while full: write is dropped, `tx_dat` unchanged.

## Timing
- Reset (asynchronous, any time including mid-transfer) sets:
  - `rx_valid=0`, `tx_valid=0`, `rx_dat=0`, `tx_dat=0`.
  - Resulting outputs: `to232_rdy=0`, `to232_dat=0`, `from232_ack=1`, `avm_readdata` = 0 for address 0, 0x40 for address 8.
- Latency, incoming path: a byte accepted at edge N is reported in status bit 7 from cycle N+1 onward.
- Latency, outgoing path: a TX write at edge N drives `to232_rdy=1` from cycle N+1.
- Buffer depth is one, so there is no bypass: a byte cannot enter and leave the same buffer in one cycle.
- Simultaneous events:
  - A bus RX read and an incoming transfer never coincide, because `from232_ack` requires empty and a valid read requires full.
  - Same holds for a TX write and an outgoing transfer.
  - RX and TX activity in the same cycle are independent.
- Throughput: at most one byte per two cycles per direction.
- No dependence on `avm_read`/`avm_write` except through the `avm_actually_*` strobes.

## Test plan
- Reset, then read address 8 → 0x40; read address 0 → 0x00; `from232_ack=1`, `to232_rdy=0`.
- Incoming transfer 0xA5 → next cycle status reads 0xC0 and `from232_ack=0`. Then read address 0 → 0x000000A5; next cycle status 0x40, `from232_ack=1`.
- Write 0x1234_5667 to address 4 → next cycle `to232_rdy=1`, `to232_dat=0x67`, status 0x00. Hold `to232_ack=0` for 5 cycles: output stays 0x67. Pulse ack → next cycle status 0x40.
- Second TX write while `tx_valid=1` → `tx_dat` stays 0x67, `tx_src_rdy=1` with `tx_src_ack=0`. RX read while empty → stale data, `rx_dst_rdy=1` with `rx_dst_ack=0`.
- Stream 128 random-gapped incoming bytes and 62 bus TX writes under random ack back-pressure. Expect all RX bytes read back in order with none lost, and 62 bytes emitted on `to232` in write order.
- Assert reset while both buffers are full → immediately `to232_rdy=0`, `from232_ack=1`, status 0x40.

Source files
------------

// File: rtl/test_slave.sv
// Avalon-MM UART register slave model: one-entry RX and TX byte buffers
// bridged to byte-wide rdy/ack streams, with RX-data, TX-data and status registers.
module test_slave (
    input  logic        avm_clk,
    input  logic        avm_rst_n,
    input  logic [4:0]  avm_address,
    input  logic        avm_actually_read,
    output logic [31:0] avm_readdata,
    input  logic        avm_actually_write,
    input  logic [31:0] avm_writedata,
    output logic        to232_rdy,
    input  logic        to232_ack,
    output logic [7:0]  to232_dat,
    input  logic        from232_rdy,
    output logic        from232_ack,
    input  logic [7:0]  from232_dat
);

    localparam logic [4:0] ADDR_RX   = 5'd0;
    localparam logic [4:0] ADDR_TX   = 5'd4;
    localparam logic [4:0] ADDR_STAT = 5'd8;

    logic       r_rx_valid;
    logic [7:0] r_rx_dat;
    logic       r_tx_valid;
    logic [7:0] r_tx_dat;

    // Handshake nets watched by external protocol checkers: a transfer is rdy && ack.
    logic tx_src_rdy;
    logic tx_src_ack;
    logic rx_dst_rdy;
    logic rx_dst_ack;

    logic w_rx_in;
    logic w_rx_rd;
    logic w_tx_wr;
    logic w_tx_out;
    logic w_unused_wdata;

    assign rx_dst_rdy = avm_actually_read && (avm_address == ADDR_RX);
    assign rx_dst_ack = r_rx_valid;
    assign tx_src_rdy = avm_actually_write && (avm_address == ADDR_TX);
    assign tx_src_ack = !r_tx_valid;

    assign from232_ack = !r_rx_valid;
    assign to232_rdy   = r_tx_valid;
    assign to232_dat   = r_tx_dat;

    assign w_rx_in  = from232_rdy && from232_ack;
    assign w_rx_rd  = rx_dst_rdy && rx_dst_ack;
    assign w_tx_wr  = tx_src_rdy && tx_src_ack;
    assign w_tx_out = to232_rdy && to232_ack;

    assign w_unused_wdata = &{1'b0, avm_writedata[31:8]};

    // Incoming accept needs empty and a bus read needs full, so they never collide.
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            r_rx_valid <= 1'b0;
            r_rx_dat   <= 8'h00;
        end else if (w_rx_in) begin
            r_rx_valid <= 1'b1;
            r_rx_dat   <= from232_dat;
        end else if (w_rx_rd) begin
            r_rx_valid <= 1'b0;
        end
    end

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            r_tx_valid <= 1'b0;
            r_tx_dat   <= 8'h00;
        end else if (w_tx_wr) begin
            r_tx_valid <= 1'b1;
            r_tx_dat   <= avm_writedata[7:0];
        end else if (w_tx_out) begin
            r_tx_valid <= 1'b0;
        end
    end

    always_comb begin
        avm_readdata = 32'h0;
        case (avm_address)
            ADDR_RX:   avm_readdata = {24'h0, r_rx_dat};
            ADDR_STAT: avm_readdata = {24'h0, r_rx_valid, !r_tx_valid, 6'b0};
            default:   avm_readdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_test_slave.sv
// Bench for test_slave: directed vector table, randomized traffic against a
// queue-based buffer model, and an asynchronous reset with both buffers full.
module tb_test_slave;

    logic        clk;
    logic        rst_n;
    logic [4:0]  avm_address;
    logic        avm_actually_read;
    logic [31:0] avm_readdata;
    logic        avm_actually_write;
    logic [31:0] avm_writedata;
    logic        to232_rdy;
    logic        to232_ack;
    logic [7:0]  to232_dat;
    logic        from232_rdy;
    logic        from232_ack;
    logic [7:0]  from232_dat;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_exp_q[$];

    test_slave dut (
        .avm_clk           (clk),
        .avm_rst_n         (rst_n),
        .avm_address       (avm_address),
        .avm_actually_read (avm_actually_read),
        .avm_readdata      (avm_readdata),
        .avm_actually_write(avm_actually_write),
        .avm_writedata     (avm_writedata),
        .to232_rdy         (to232_rdy),
        .to232_ack         (to232_ack),
        .to232_dat         (to232_dat),
        .from232_rdy       (from232_rdy),
        .from232_ack       (from232_ack),
        .from232_dat       (from232_dat)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic        frdy;
        logic [7:0]  fdat;
        logic        tack;
        logic [31:0] e_rdata;
        logic        e_fack;
        logic        e_trdy;
        logic [7:0]  e_tdat;
        logic [3:0]  e_nets;   // {tx_src_rdy, tx_src_ack, rx_dst_rdy, rx_dst_ack}
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        avm_address        = 5'd8;
        avm_actually_read  = 1'b0;
        avm_actually_write = 1'b0;
        avm_writedata      = 32'h0;
        from232_rdy        = 1'b0;
        from232_dat        = 8'h00;
        to232_ack          = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vectors();
        for (int i = 0; i < 18; i++) begin
            avm_address        = vecs[i].addr;
            avm_actually_read  = vecs[i].rd;
            avm_actually_write = vecs[i].wr;
            avm_writedata      = vecs[i].wdata;
            from232_rdy        = vecs[i].frdy;
            from232_dat        = vecs[i].fdat;
            to232_ack          = vecs[i].tack;
            #1;
            chk($sformatf("vec%0d readdata", i), avm_readdata, vecs[i].e_rdata);
            chk($sformatf("vec%0d from232_ack", i), {31'b0, from232_ack}, {31'b0, vecs[i].e_fack});
            chk($sformatf("vec%0d to232_rdy", i), {31'b0, to232_rdy}, {31'b0, vecs[i].e_trdy});
            chk($sformatf("vec%0d to232_dat", i), {24'b0, to232_dat}, {24'b0, vecs[i].e_tdat});
            chk($sformatf("vec%0d nets", i),
                {28'b0, dut.tx_src_rdy, dut.tx_src_ack, dut.rx_dst_rdy, dut.rx_dst_ack},
                {28'b0, vecs[i].e_nets});
            step();
        end
        idle_inputs();
    endtask

    task automatic run_random();
        logic [7:0] rx_src[128];
        logic [7:0] tx_src[62];
        int rx_sent = 0, rx_read = 0, tx_wr = 0, tx_out = 0, gap = 0, cyc = 0, op;
        bit m_rx = 0, m_tx = 0, new_rx, new_tx;
        for (int i = 0; i < 128; i++) rx_src[i] = 8'($urandom);
        for (int i = 0; i < 62; i++)  tx_src[i] = 8'($urandom);
        while ((rx_read < 128 || tx_out < 62) && cyc < 20000) begin
            from232_rdy        = (rx_sent < 128) && (gap == 0);
            from232_dat        = from232_rdy ? rx_src[rx_sent] : 8'($urandom);
            avm_address        = 5'd8;
            avm_actually_read  = 1'b0;
            avm_actually_write = 1'b0;
            avm_writedata      = $urandom;
            op = $urandom_range(0, 3);
            if (m_rx && op < 2) begin
                avm_address       = 5'd0;
                avm_actually_read = 1'b1;
            end else if (tx_wr < 62 && !m_tx && op >= 1) begin
                avm_address        = 5'd4;
                avm_actually_write = 1'b1;
                avm_writedata[7:0] = tx_src[tx_wr];
            end
            to232_ack = ($urandom_range(0, 2) == 0);
            #1;
            chk("rnd from232_ack", {31'b0, from232_ack}, {31'b0, !m_rx});
            chk("rnd to232_rdy", {31'b0, to232_rdy}, {31'b0, m_tx});
            if (avm_actually_read) begin
                chk("rnd rx_byte", avm_readdata, {24'b0, rx_exp_q.pop_front()});
                rx_read++;
            end else if (avm_address == 5'd8) begin
                chk("rnd status", avm_readdata, {24'b0, m_rx, !m_tx, 6'b0});
            end else begin
                chk("rnd tx_addr_read", avm_readdata, 32'h0);
            end
            new_rx = m_rx;
            new_tx = m_tx;
            if (from232_rdy && !m_rx) begin
                new_rx = 1;
                rx_exp_q.push_back(rx_src[rx_sent]);
                rx_sent++;
                gap = $urandom_range(0, 3);
            end else if (gap > 0) begin
                gap--;
            end
            if (avm_actually_read) new_rx = 0;
            if (m_tx && to232_ack) begin
                chk("rnd tx_byte", {24'b0, to232_dat}, {24'b0, tx_exp_q.pop_front()});
                tx_out++;
                new_tx = 0;
            end
            if (avm_actually_write) begin
                new_tx = 1;
                tx_exp_q.push_back(tx_src[tx_wr]);
                tx_wr++;
            end
            m_rx = new_rx;
            m_tx = new_tx;
            step();
            cyc++;
        end
        chk("rnd rx_count", rx_read, 128);
        chk("rnd tx_count", tx_out, 62);
        chk("rnd queues_empty", rx_exp_q.size() + tx_exp_q.size(), 0);
        idle_inputs();
        // Drain so both buffers are empty for the following sequence.
        if (m_rx) begin
            avm_address = 5'd0;
            avm_actually_read = 1'b1;
            step();
        end
        to232_ack = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic run_reset_full();
        avm_address        = 5'd4;
        avm_actually_write = 1'b1;
        avm_writedata      = 32'h0000_005A;
        from232_rdy        = 1'b1;
        from232_dat        = 8'h3C;
        step();
        idle_inputs();
        #1;
        chk("full status", avm_readdata, 32'h80);
        chk("full to232_rdy", {31'b0, to232_rdy}, 32'h1);
        chk("full to232_dat", {24'b0, to232_dat}, 32'h5A);
        chk("full from232_ack", {31'b0, from232_ack}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst to232_rdy", {31'b0, to232_rdy}, 32'h0);
        chk("rst to232_dat", {24'b0, to232_dat}, 32'h0);
        chk("rst from232_ack", {31'b0, from232_ack}, 32'h1);
        chk("rst status", avm_readdata, 32'h40);
        avm_address = 5'd0;
        #1;
        chk("rst rx_data", avm_readdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        //            addr  rd wr wdata          frdy fdat  tack e_rdata        fack trdy tdat   nets
        vecs[0]  = '{5'd8, 0, 0, 32'h0,         0, 8'h00, 0, 32'h40,        1, 0, 8'h00, 4'b0100};
        vecs[1]  = '{5'd0, 0, 0, 32'h0,         0, 8'h00, 0, 32'h00,        1, 0, 8'h00, 4'b0100};
        vecs[2]  = '{5'd8, 0, 0, 32'h0,         1, 8'hA5, 0, 32'h40,        1, 0, 8'h00, 4'b0100};
        vecs[3]  = '{5'd8, 0, 0, 32'h0,         0, 8'h00, 0, 32'hC0,        0, 0, 8'h00, 4'b0101};
        vecs[4]  = '{5'd0, 1, 0, 32'h0,         0, 8'h00, 0, 32'hA5,        0, 0, 8'h00, 4'b0111};
        vecs[5]  = '{5'd8, 0, 0, 32'h0,         0, 8'h00, 0, 32'h40,        1, 0, 8'h00, 4'b0100};
        vecs[6]  = '{5'd4, 0, 1, 32'h1234_5667, 0, 8'h00, 0, 32'h00,        1, 0, 8'h00, 4'b1100};
        vecs[7]  = '{5'd8, 0, 0, 32'h0,         0, 8'h00, 0, 32'h00,        1, 1, 8'h67, 4'b0000};
        vecs[8]  = '{5'd4, 0, 1, 32'h0000_00AA, 0, 8'h00, 0, 32'h00,        1, 1, 8'h67, 4'b1000};
        vecs[9]  = '{5'd8, 0, 0, 32'h0,         0, 8'h00, 0, 32'h00,        1, 1, 8'h67, 4'b0000};
        vecs[10] = '{5'd8, 0, 0, 32'h0,         0, 8'h00, 0, 32'h00,        1, 1, 8'h67, 4'b0000};
        vecs[11] = '{5'd8, 0, 0, 32'h0,         0, 8'h00, 0, 32'h00,        1, 1, 8'h67, 4'b0000};
        vecs[12] = '{5'd8, 0, 0, 32'h0,         0, 8'h00, 0, 32'h00,        1, 1, 8'h67, 4'b0000};
        vecs[13] = '{5'd8, 0, 0, 32'h0,         0, 8'h00, 1, 32'h00,        1, 1, 8'h67, 4'b0000};
        vecs[14] = '{5'd8, 0, 0, 32'h0,         0, 8'h00, 0, 32'h40,        1, 0, 8'h67, 4'b0100};
        vecs[15] = '{5'd0, 1, 0, 32'h0,         0, 8'h00, 0, 32'hA5,        1, 0, 8'h67, 4'b0110};
        vecs[16] = '{5'd8, 0, 1, 32'hFFFF_FFFF, 0, 8'h00, 0, 32'h40,        1, 0, 8'h67, 4'b0100};
        vecs[17] = '{5'd8, 0, 0, 32'h0,         0, 8'h00, 0, 32'h40,        1, 0, 8'h67, 4'b0100};

        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_vectors();
        run_random();
        run_reset_full();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
